vga_sync_generator: RTL and testbench

//  640x480@60Hz VGA timing stage for the Pong display.

---
 rtl/vga_sync_generator.sv | 99 +++++++++
 tb/tb_vga_sync_generator.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_generator.sv
// 640x480@60Hz VGA raster timing for the Pong display.
// Ports: Clock/Reset (sync, active-high), CRTclock (pixel-rate data input),
//   PixelTick, HSYNC, VSYNC, VideoOn, PixelX, PixelY, FrameStart (all registered).
module vga_sync_generator #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter bit SYNC_POL  = 1'b0,
  parameter int CNT_W     = 10
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             CRTclock,
  output logic             PixelTick,
  output logic             HSYNC,
  output logic             VSYNC,
  output logic             VideoOn,
  output logic [CNT_W-1:0] PixelX,
  output logic [CNT_W-1:0] PixelY,
  output logic             FrameStart
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VEND  = CNT_W'(H_VISIBLE);
  localparam logic [CNT_W-1:0] V_VEND  = CNT_W'(V_VISIBLE);
  localparam logic [CNT_W-1:0] HS_BEG  = CNT_W'(H_VISIBLE + H_FRONT);
  localparam logic [CNT_W-1:0] HS_END  = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [CNT_W-1:0] VS_BEG  = CNT_W'(V_VISIBLE + V_FRONT);
  localparam logic [CNT_W-1:0] VS_END  = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  logic             crt_d;
  logic             tick;
  logic             line_end;
  logic             frame_end;
  logic [CNT_W-1:0] x_nxt;
  logic [CNT_W-1:0] y_nxt;
  logic             hs_nxt;
  logic             vs_nxt;
  logic             von_nxt;
  logic             fs_nxt;

  // CRTclock is treated as data; one advance per observed rising edge.
  assign tick = CRTclock & ~crt_d;

  always_comb begin
    line_end  = (PixelX == H_LAST);
    frame_end = (PixelY == V_LAST);
    x_nxt     = line_end ? '0 : PixelX + ONE;
    y_nxt     = PixelY;
    if (line_end) begin
      y_nxt = frame_end ? '0 : PixelY + ONE;
    end
  end

  // Decode from the next position so all outputs update together.
  always_comb begin
    hs_nxt  = (x_nxt >= HS_BEG) && (x_nxt < HS_END);
    vs_nxt  = (y_nxt >= VS_BEG) && (y_nxt < VS_END);
    von_nxt = (x_nxt < H_VEND) && (y_nxt < V_VEND);
    fs_nxt  = (x_nxt == '0) && (y_nxt == '0);
  end

  // Reset parks on the last pixel so the first rise lands on (0,0);
  // crt_d=1 stops a CRTclock already high at release from ticking.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      crt_d      <= 1'b1;
      PixelX     <= H_LAST;
      PixelY     <= V_LAST;
      HSYNC      <= ~SYNC_POL;
      VSYNC      <= ~SYNC_POL;
      VideoOn    <= 1'b0;
      PixelTick  <= 1'b0;
      FrameStart <= 1'b0;
    end else begin
      crt_d      <= CRTclock;
      PixelTick  <= tick;
      FrameStart <= tick & fs_nxt;
      if (tick) begin
        PixelX  <= x_nxt;
        PixelY  <= y_nxt;
        HSYNC   <= hs_nxt ? SYNC_POL : ~SYNC_POL;
        VSYNC   <= vs_nxt ? SYNC_POL : ~SYNC_POL;
        VideoOn <= von_nxt;
      end
    end
  end

endmodule

// File: tb/tb_vga_sync_generator.sv
// Bench for vga_sync_generator: full-size instance plus a shrunken
// geometry instance so whole frames fit in a short run.
module tb_vga_sync_generator;

  localparam int W   = 10;
  localparam int SHV = 20;
  localparam int SHF = 2;
  localparam int SHS = 3;
  localparam int SHB = 3;
  localparam int SVV = 12;
  localparam int SVF = 2;
  localparam int SVS = 2;
  localparam int SVB = 3;

  logic         Clock = 1'b0;
  logic         Reset = 1'b1;
  logic         CRTclock = 1'b0;
  logic         tick_a, hs_a, vs_a, von_a, fs_a;
  logic         tick_s, hs_s, vs_s, von_s, fs_s;
  logic [W-1:0] x_a, y_a, x_s, y_s;

  vga_sync_generator dut_a (
    .Clock(Clock), .Reset(Reset), .CRTclock(CRTclock),
    .PixelTick(tick_a), .HSYNC(hs_a), .VSYNC(vs_a),
    .VideoOn(von_a), .PixelX(x_a), .PixelY(y_a),
    .FrameStart(fs_a)
  );

  vga_sync_generator #(
    .H_VISIBLE(SHV), .H_FRONT(SHF), .H_SYNC(SHS), .H_BACK(SHB),
    .V_VISIBLE(SVV), .V_FRONT(SVF), .V_SYNC(SVS), .V_BACK(SVB),
    .SYNC_POL(1'b0), .CNT_W(W)
  ) dut_s (
    .Clock(Clock), .Reset(Reset), .CRTclock(CRTclock),
    .PixelTick(tick_s), .HSYNC(hs_s), .VSYNC(vs_s),
    .VideoOn(von_s), .PixelX(x_s), .PixelY(y_s),
    .FrameStart(fs_s)
  );

  always #5 Clock = ~Clock;

  int checks = 0;
  int errors = 0;

  // geometry table: index 0 = full VGA, 1 = small
  int hv[2] = '{640, SHV};
  int hf[2] = '{16, SHF};
  int hw[2] = '{96, SHS};
  int hb[2] = '{48, SHB};
  int vv[2] = '{480, SVV};
  int vf[2] = '{10, SVF};
  int vw[2] = '{2, SVS};
  int vb[2] = '{33, SVB};

  // model: linear pixel index within the frame
  int pos[2];
  bit prev;
  bit mtick;

  bit agg_on = 0;
  bit s_seen = 0;
  int s_ticks = 0;
  int s_vs = 0;
  bit a_cnt_on = 0;
  int a_hs = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int htot(input int i);
    return hv[i] + hf[i] + hw[i] + hb[i];
  endfunction

  function automatic int vtot(input int i);
    return vv[i] + vf[i] + vw[i] + vb[i];
  endfunction

  task automatic check_dut(input int i, input string nm,
                           input logic tk, input logic hs,
                           input logic vs, input logic von,
                           input logic fs,
                           input logic [W-1:0] x,
                           input logic [W-1:0] y);
    int xe, ye;
    bit hse, vse, vone, fse;
    xe   = pos[i] % htot(i);
    ye   = pos[i] / htot(i);
    hse  = !(xe >= hv[i] + hf[i] && xe < hv[i] + hf[i] + hw[i]);
    vse  = !(ye >= vv[i] + vf[i] && ye < vv[i] + vf[i] + vw[i]);
    vone = (xe < hv[i]) && (ye < vv[i]);
    fse  = mtick && pos[i] == 0;
    chk({nm, "_x"}, 32'(x), xe);
    chk({nm, "_y"}, 32'(y), ye);
    chk({nm, "_hsync"}, 32'(hs), 32'(hse));
    chk({nm, "_vsync"}, 32'(vs), 32'(vse));
    chk({nm, "_video"}, 32'(von), 32'(vone));
    chk({nm, "_tick"}, 32'(tk), 32'(mtick));
    chk({nm, "_fstart"}, 32'(fs), 32'(fse));
  endtask

  task automatic step(input bit rst, input bit crt);
    Reset = rst;
    CRTclock = crt;
    @(posedge Clock);
    #1;
    mtick = !rst && crt && !prev;
    prev = rst ? 1'b1 : crt;
    for (int i = 0; i < 2; i++) begin
      if (rst)
        pos[i] = htot(i) * vtot(i) - 1;
      else if (mtick)
        pos[i] = (pos[i] + 1) % (htot(i) * vtot(i));
    end
    check_dut(0, "a", tick_a, hs_a, vs_a, von_a, fs_a, x_a, y_a);
    check_dut(1, "s", tick_s, hs_s, vs_s, von_s, fs_s, x_s, y_s);
    if (a_cnt_on && tick_a && !hs_a) a_hs++;
    if (agg_on && tick_s) begin
      if (fs_s) begin
        if (s_seen) begin
          chk("s_frame_len", s_ticks, htot(1) * vtot(1));
          chk("s_vsync_ticks", s_vs, SVS * htot(1));
        end
        s_seen = 1;
        s_ticks = 0;
        s_vs = 0;
      end
      s_ticks++;
      if (!vs_s) s_vs++;
    end
  endtask

  task automatic run_ticks(input int n);
    repeat (n) begin
      repeat ($urandom_range(1, 3)) step(0, 0);
      repeat ($urandom_range(1, 3)) step(0, 1);
    end
  endtask

  initial begin
    // reset held while CRTclock toggles
    for (int k = 0; k < 20; k++) step(1, k[0]);
    // release with CRTclock high: no tick
    step(0, 1);
    step(0, 0);
    step(0, 1);
    step(0, 1);
    // one full line on the big instance
    a_cnt_on = 1;
    run_ticks(799);
    a_cnt_on = 0;
    chk("a_hsync_width", a_hs, 96);
    run_ticks(10);
    // whole frames on the small instance
    agg_on = 1;
    run_ticks(2 * SHV * 0 + 3 * 28 * 19 + 10);
    agg_on = 0;
    // steady high, short low, single-clock high
    repeat (50) step(0, 1);
    repeat (3) step(0, 0);
    step(0, 1);
    repeat (2) step(0, 0);
    // reset coincident with a rising edge mid-frame
    run_ticks(37);
    step(0, 0);
    step(1, 1);
    step(0, 1);
    step(0, 0);
    step(0, 1);
    step(0, 0);
    // random tail with occasional resets
    for (int k = 0; k < 1500; k++) begin
      step(($urandom_range(0, 99) == 0), $urandom_range(0, 1) == 1);
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
